// File: rtl/br_update_queue_if.sv
// Branch-result bus between the integer issue pipes and the branch update queue.
// One lane per integer pipe; lane 0 carries the oldest result of the cycle.
//   res_valid    : per-lane executed-branch valid
//   res_taken    : per-lane resolved direction
//   res_mispred  : per-lane misprediction flag
//   res_is_cond  : per-lane conditional-branch flag
//   res_hist     : per-lane global history captured at prediction
//   res_prev_cnt : per-lane counter value read at prediction
//   res_ready    : queue can take a full set of IN_WIDTH results this cycle
// master = issue pipes, slave = update queue.
interface br_update_queue_if #(
    parameter int IN_WIDTH  = 2,
    parameter int GH_WIDTH  = 10,
    parameter int CNT_WIDTH = 2
);
    logic [IN_WIDTH-1:0]           res_valid;
    logic [IN_WIDTH-1:0]           res_taken;
    logic [IN_WIDTH-1:0]           res_mispred;
    logic [IN_WIDTH-1:0]           res_is_cond;
    logic [IN_WIDTH*GH_WIDTH-1:0]  res_hist;
    logic [IN_WIDTH*CNT_WIDTH-1:0] res_prev_cnt;
    logic                          res_ready;

    modport master (
        output res_valid, res_taken, res_mispred, res_is_cond, res_hist, res_prev_cnt,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_taken, res_mispred, res_is_cond, res_hist, res_prev_cnt,
        output res_ready
    );
endinterface

// File: rtl/br_update_queue.sv
// Branch-predictor update queue.
// Buffers executed branch results and retires one per cycle into the pattern
// history table (PHT) through a single write port. After reset the whole table
// is swept to the weakly-taken value before results are accepted. A registered
// history-recovery request is raised for the oldest mispredicted lane.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   resBus        : branch-result bus (slave side), see br_update_queue_if
//   pht_we/wa/wv  : PHT write enable / address / counter value
//   recover_valid : one-cycle history-recovery pulse
//   recover_hist  : corrected global history for recovery
//   init_done     : table initialisation sweep finished
//
// Build option: define BR_UPDATE_BYPASS_EN to let lane 0 write the table in
// the same cycle when the queue is empty, skipping the queue.
module br_update_queue #(
    parameter int IN_WIDTH  = 2,
    parameter int ENTRY_NUM = 8,
    parameter int GH_WIDTH  = 10,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    br_update_queue_if.slave     resBus,
    output logic                 pht_we,
    output logic [GH_WIDTH-1:0]  pht_wa,
    output logic [CNT_WIDTH-1:0] pht_wv,
    output logic                 recover_valid,
    output logic [GH_WIDTH-1:0]  recover_hist,
    output logic                 init_done
);

    localparam int PTR_W   = $clog2(ENTRY_NUM);
    localparam int OCC_W   = PTR_W + 1;
    localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;
    localparam logic [CNT_WIDTH-1:0] INIT_CNT    = CNT_WIDTH'(CNT_MAX / 2 + 1);
    localparam logic [OCC_W-1:0]     READY_LIMIT = OCC_W'(ENTRY_NUM - IN_WIDTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [GH_WIDTH-1:0]    sweepIdx;
    logic [PTR_W-1:0]       rdPtr;
    logic [PTR_W-1:0]       wrPtr;
    logic [OCC_W-1:0]       occ;

    // Queue storage carries data only, so it is never reset.
    logic [GH_WIDTH-1:0]    qHist  [ENTRY_NUM];
    logic [CNT_WIDTH-1:0]   qPrev  [ENTRY_NUM];
    logic                   qTaken [ENTRY_NUM];

    logic                   isRun;
    logic                   accept;
    logic                   popFire;
    logic                   bypassFire;
    logic [IN_WIDTH-1:0]    pushEn;
    logic [OCC_W-1:0]       pushCount;
    logic [PTR_W-1:0]       slotIdx [IN_WIDTH];
    logic                   recVld_p0;
    logic [GH_WIDTH-1:0]    recHist_p0;

    // Saturating 2-direction counter update.
    function automatic logic [CNT_WIDTH-1:0] satUpdate(
        input logic [CNT_WIDTH-1:0] prev,
        input logic                 taken
    );
        if (taken)
            return (prev == '1) ? prev : prev + CNT_WIDTH'(1);
        else
            return (prev == '0) ? prev : prev - CNT_WIDTH'(1);
    endfunction

    // History as it should look after this branch: conditional branches shift
    // in their real outcome, unconditional ones leave history untouched.
    function automatic logic [GH_WIDTH-1:0] fixHist(
        input logic [GH_WIDTH-1:0] hist,
        input logic                taken,
        input logic                isCond
    );
        return isCond ? {hist[GH_WIDTH-2:0], taken} : hist;
    endfunction

    assign isRun              = (state == RUN);
    assign resBus.res_ready   = isRun && (occ <= READY_LIMIT);
    assign accept             = resBus.res_ready;
    assign popFire            = isRun && (occ != '0);
    assign init_done          = isRun;

`ifdef BR_UPDATE_BYPASS_EN
    // Empty queue: lane 0 goes straight to the table port, which is free.
    assign bypassFire = isRun && (occ == '0) && resBus.res_valid[0];
`else
    assign bypassFire = 1'b0;
`endif

    // Compact valid lanes into consecutive slots starting at wrPtr.
    always_comb begin
        pushCount = '0;
        pushEn    = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            slotIdx[i] = wrPtr + pushCount[PTR_W-1:0];
            if (accept && resBus.res_valid[i] && !(bypassFire && (i == 0))) begin
                pushEn[i] = 1'b1;
                pushCount = pushCount + OCC_W'(1);
            end
        end
    end

    // Descending scan so the lowest mispredicting lane overrides later ones.
    always_comb begin
        recVld_p0  = 1'b0;
        recHist_p0 = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (accept && resBus.res_valid[i] && resBus.res_mispred[i]) begin
                recVld_p0  = 1'b1;
                recHist_p0 = fixHist(resBus.res_hist[i*GH_WIDTH +: GH_WIDTH],
                                     resBus.res_taken[i], resBus.res_is_cond[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        pht_we    = 1'b0;
        pht_wa    = '0;
        pht_wv    = '0;
        case (state)
            INIT: begin
                pht_we = 1'b1;
                pht_wa = sweepIdx;
                pht_wv = INIT_CNT;
                if (sweepIdx == '1) stateNext = RUN;
            end
            RUN: begin
                if (popFire) begin
                    pht_we = 1'b1;
                    pht_wa = qHist[rdPtr];
                    pht_wv = satUpdate(qPrev[rdPtr], qTaken[rdPtr]);
                end else if (bypassFire) begin
                    pht_we = 1'b1;
                    pht_wa = resBus.res_hist[GH_WIDTH-1:0];
                    pht_wv = satUpdate(resBus.res_prev_cnt[CNT_WIDTH-1:0], resBus.res_taken[0]);
                end
            end
            default: stateNext = INIT;
        endcase
    end

    // ---- control stage: pointers, occupancy, sweep, recovery ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sweepIdx      <= '0;
            rdPtr         <= '0;
            wrPtr         <= '0;
            occ           <= '0;
            recover_valid <= 1'b0;
            recover_hist  <= '0;
        end else begin
            if (state == INIT) sweepIdx <= sweepIdx + GH_WIDTH'(1);
            if (popFire)       rdPtr    <= rdPtr + PTR_W'(1);
            wrPtr         <= wrPtr + pushCount[PTR_W-1:0];
            occ           <= occ + pushCount - OCC_W'(popFire);
            recover_valid <= recVld_p0;
            if (recVld_p0) recover_hist <= recHist_p0;
        end
    end

    // ---- data stage: queue entry capture ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (pushEn[i]) begin
                qHist[slotIdx[i]]  <= resBus.res_hist[i*GH_WIDTH +: GH_WIDTH];
                qPrev[slotIdx[i]]  <= resBus.res_prev_cnt[i*CNT_WIDTH +: CNT_WIDTH];
                qTaken[slotIdx[i]] <= resBus.res_taken[i];
            end
        end
    end

endmodule

// File: tb/tb_br_update_queue.sv
// Testbench for br_update_queue (IN_WIDTH=2, ENTRY_NUM=8, GH_WIDTH=10, CNT_WIDTH=2).
module tb_br_update_queue;

    localparam int IN_WIDTH  = 2;
    localparam int ENTRY_NUM = 8;
    localparam int GH_WIDTH  = 10;
    localparam int CNT_WIDTH = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 pht_we;
    logic [GH_WIDTH-1:0]  pht_wa;
    logic [CNT_WIDTH-1:0] pht_wv;
    logic                 recover_valid;
    logic [GH_WIDTH-1:0]  recover_hist;
    logic                 init_done;

    always #5 clk = ~clk;

    br_update_queue_if #(.IN_WIDTH(IN_WIDTH), .GH_WIDTH(GH_WIDTH), .CNT_WIDTH(CNT_WIDTH)) resBus ();

    br_update_queue #(
        .IN_WIDTH(IN_WIDTH), .ENTRY_NUM(ENTRY_NUM), .GH_WIDTH(GH_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .resBus(resBus),
        .pht_we(pht_we), .pht_wa(pht_wa), .pht_wv(pht_wv),
        .recover_valid(recover_valid), .recover_hist(recover_hist), .init_done(init_done)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0] valid, taken, mispred, cond;
        logic [9:0] h0, h1;
        logic [1:0] p0, p1;
        logic       eReady, eWe;
        logic [9:0] eWa;
        logic [1:0] eWv;
        logic       eRec;
        logic [9:0] eRecHist;
    } vec_t;

    typedef struct {
        logic [9:0] h;
        logic [1:0] v;
    } wr_t;

    vec_t vecs [12];
    wr_t  sbq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] valid, input logic [1:0] taken, input logic [1:0] mispred,
                         input logic [1:0] cond, input logic [9:0] h0, input logic [9:0] h1,
                         input logic [1:0] p0, input logic [1:0] p1);
        resBus.res_valid    = valid;
        resBus.res_taken    = taken;
        resBus.res_mispred  = mispred;
        resBus.res_is_cond  = cond;
        resBus.res_hist     = {h1, h0};
        resBus.res_prev_cnt = {p1, p0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 2'd0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] taken, input logic [1:0] mispred,
                                input logic [1:0] cond, input logic [9:0] h0, input logic [9:0] h1,
                                input logic [1:0] p0, input logic [1:0] p1, input logic eReady,
                                input logic eWe, input logic [9:0] eWa, input logic [1:0] eWv,
                                input logic eRec, input logic [9:0] eRecHist);
        vec_t v;
        v.valid = valid; v.taken = taken; v.mispred = mispred; v.cond = cond;
        v.h0 = h0; v.h1 = h1; v.p0 = p0; v.p1 = p1;
        v.eReady = eReady; v.eWe = eWe; v.eWa = eWa; v.eWv = eWv;
        v.eRec = eRec; v.eRecHist = eRecHist;
        return v;
    endfunction

    function automatic logic [1:0] satModel(input logic [1:0] p, input logic t);
        if (t) return (p == 2'd3) ? 2'd3 : p + 2'd1;
        else   return (p == 2'd0) ? 2'd0 : p - 2'd1;
    endfunction

    // Sweep check: n cycles of INIT writes starting at address 0.
    task automatic runSweep(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check("sweep", {17'd0, pht_we, pht_wa, pht_wv, resBus.res_ready, init_done},
                  {17'd0, 1'b1, GH_WIDTH'(i), 2'd2, 1'b0, 1'b0});
            tick();
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_recover_valid", {31'd0, recover_valid}, 32'd0);
        check("rst_recover_hist",  {22'd0, recover_hist}, 32'd0);
        check("rst_res_ready",     {31'd0, resBus.res_ready}, 32'd0);
        check("rst_init_done",     {31'd0, init_done}, 32'd0);
        rst = 1'b0;

        // Interrupt the sweep part-way, then let it run to completion.
        runSweep(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runSweep(1 << GH_WIDTH);
        #1;
        check("run_init_done", {31'd0, init_done}, 32'd1);
        check("run_ready",     {31'd0, resBus.res_ready}, 32'd1);
        check("run_idle_we",   {31'd0, pht_we}, 32'd0);
        tick();

`ifndef BR_UPDATE_BYPASS_EN
        //        valid  taken  misp   cond   h0      h1      p0 p1  rdy we wa      wv rec rhist
        vecs[0]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 0, 10'h000, 0, 0, 10'h000);
        vecs[1]  = mk(2'b11, 2'b01, 2'b00, 2'b00, 10'h155, 10'h0AA, 3, 0, 1, 0, 10'h000, 0, 0, 10'h000);
        vecs[2]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 1, 10'h155, 3, 0, 10'h000);
        vecs[3]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 1, 10'h0AA, 0, 0, 10'h000);
        vecs[4]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 0, 10'h000, 0, 0, 10'h000);
        vecs[5]  = mk(2'b11, 2'b10, 2'b11, 2'b01, 10'h3FF, 10'h001, 2, 1, 1, 0, 10'h000, 0, 0, 10'h000);
        vecs[6]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 1, 10'h3FF, 1, 1, 10'h3FE);
        vecs[7]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 1, 10'h001, 2, 0, 10'h000);
        vecs[8]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 0, 10'h000, 0, 0, 10'h000);
        vecs[9]  = mk(2'b10, 2'b10, 2'b10, 2'b10, 10'h000, 10'h200, 0, 0, 1, 0, 10'h000, 0, 0, 10'h000);
        vecs[10] = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 1, 10'h200, 1, 1, 10'h001);
        vecs[11] = mk(2'b00, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 1, 0, 10'h000, 0, 0, 10'h000);

        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].valid, vecs[k].taken, vecs[k].mispred, vecs[k].cond,
                  vecs[k].h0, vecs[k].h1, vecs[k].p0, vecs[k].p1);
            #1;
            check($sformatf("vec%0d_ready", k), {31'd0, resBus.res_ready}, {31'd0, vecs[k].eReady});
            check($sformatf("vec%0d_we", k), {31'd0, pht_we}, {31'd0, vecs[k].eWe});
            if (vecs[k].eWe) begin
                check($sformatf("vec%0d_wa", k), {22'd0, pht_wa}, {22'd0, vecs[k].eWa});
                check($sformatf("vec%0d_wv", k), {30'd0, pht_wv}, {30'd0, vecs[k].eWv});
            end
            check($sformatf("vec%0d_rec", k), {31'd0, recover_valid}, {31'd0, vecs[k].eRec});
            if (vecs[k].eRec)
                check($sformatf("vec%0d_rechist", k), {22'd0, recover_hist}, {22'd0, vecs[k].eRecHist});
            tick();
        end

        // Back-pressure: both lanes every cycle; dropped cycles carry a
        // mispredict that must not produce a recovery pulse.
        for (int c = 0; c < 10; c++) begin
            logic       expReady;
            logic [9:0] h0, h1;
            logic [1:0] p0, p1;
            expReady = (sbq.size() <= ENTRY_NUM - IN_WIDTH);
            h0 = 10'h100 + 10'(2 * c);
            h1 = 10'h101 + 10'(2 * c);
            p0 = 2'(c);
            p1 = 2'(c + 1);
            drive(2'b11, 2'b10, expReady ? 2'b00 : 2'b01, 2'b11, h0, h1, p0, p1);
            #1;
            check($sformatf("fill%0d_ready", c), {31'd0, resBus.res_ready}, {31'd0, expReady});
            check($sformatf("fill%0d_rec", c), {31'd0, recover_valid}, 32'd0);
            if (sbq.size() > 0) begin
                wr_t w;
                w = sbq.pop_front();
                check($sformatf("fill%0d_wr", c), {19'd0, pht_we, pht_wa, pht_wv}, {19'd0, 1'b1, w.h, w.v});
            end else begin
                check($sformatf("fill%0d_we", c), {31'd0, pht_we}, 32'd0);
            end
            if (expReady) begin
                sbq.push_back('{h: h0, v: satModel(p0, 1'b0)});
                sbq.push_back('{h: h1, v: satModel(p1, 1'b1)});
            end
            tick();
        end
        idle();
        for (int d = 0; d < 16 && sbq.size() > 0; d++) begin
            wr_t w;
            w = sbq.pop_front();
            #1;
            check($sformatf("drain%0d_wr", d), {19'd0, pht_we, pht_wa, pht_wv}, {19'd0, 1'b1, w.h, w.v});
            check($sformatf("drain%0d_rec", d), {31'd0, recover_valid}, 32'd0);
            tick();
        end
        #1;
        check("drain_empty_we", {31'd0, pht_we}, 32'd0);
        tick();
`else
        // Bypass: empty queue, lane 0 written in the same cycle.
        drive(2'b01, 2'b01, 2'b00, 2'b01, 10'h010, 10'h000, 2'd1, 2'd0);
        #1;
        check("byp_wr", {19'd0, pht_we, pht_wa, pht_wv}, {19'd0, 1'b1, 10'h010, 2'd2});
        tick();
        idle();
        #1;
        check("byp_empty_we", {31'd0, pht_we}, 32'd0);
        tick();
        // Lane 0 bypasses, lane 1 queues and retires next cycle.
        drive(2'b11, 2'b01, 2'b00, 2'b11, 10'h020, 10'h040, 2'd0, 2'd3);
        #1;
        check("byp2_wr0", {19'd0, pht_we, pht_wa, pht_wv}, {19'd0, 1'b1, 10'h020, 2'd1});
        tick();
        idle();
        #1;
        check("byp2_wr1", {19'd0, pht_we, pht_wa, pht_wv}, {19'd0, 1'b1, 10'h040, 2'd2});
        tick();
        #1;
        check("byp2_empty_we", {31'd0, pht_we}, 32'd0);
        tick();
`endif

        // Reset with a part-filled queue: contents must vanish.
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 2'b11, 2'b00, 2'b11, 10'h2A0 + 10'(c), 10'h2B0 + 10'(c), 2'd1, 2'd2);
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runSweep(1 << GH_WIDTH);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("post_rst%0d_we", c), {31'd0, pht_we}, 32'd0);
            check($sformatf("post_rst%0d_done", c), {31'd0, init_done}, 32'd1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
